spm: RTL and testbench
======================

Name: spm

Overview:
SPI initiator for the frequency meter's SPI slave port. It exchanges one full-duplex frame per request.
- TX word carries the counter control fields: [7:6] begin-input select, [5:4] end-input select, [3] begin request, [2] end request, [1:0] input polarity.
- RX word returns {eac, bac, cta, ctc}.
- Sits on the host/MCU-emulation side of the board model and in system benches. It generates sck and _scs from the system clock.

Parameters:
size, 66, frame length in bits (2*ctr_size+2); legal range 2..255
div, 4, sck half-period in clk cycles; legal range 1..255; must be >=2 when driving the fc slave

Ports:
clk  input  1  system clock, all logic on rising edge
_rst  input  1  synchronous active-low reset
start  input  1  request a transfer; sampled only when busy=0
pdi  input  size  word to transmit; captured on the accepted start cycle
pdo  output  size  last received word; updated only at frame end
busy  output  1  high from the cycle after accepted start until the end of GAP
done  output  1  one-cycle pulse, pdo valid in the same cycle
sck  output  1  SPI clock, mode 0 (idle low)
sdo  output  1  master out, to slave sdi, MSB first
sdi  input  1  master in, from slave sdo
_scs  output  1  active-low slave select

Behaviour:
- Reset (_rst=0 at a clk edge): state=IDLE, _scs=1, sck=0, sdo=0, busy=0, done=0, pdo=0, shift registers and counters 0. Reset mid-frame aborts immediately: _scs rises and no done pulse is produced.
- FSM states: IDLE -> SETUP -> HIGH <-> LOW -> GAP -> IDLE.
- Internal counters:
  - phase counter: counts 0..div-1 and restarts on every state change.
  - bit counter: counts 0..size-1.
- IDLE, start=1 at edge T:
  - tx shift register <= pdi; rx shift register is not cleared.
  - At T+1: _scs=0, sdo=pdi[size-1], busy=1, enter SETUP.
  - pdi changes after T have no effect.
- SETUP (div cycles, sck=0): then enter HIGH with bit=0.
- HIGH (div cycles, sck=1):
  - On the entry edge (sck 0->1), sdi is sampled: rx <= {rx[size-2:0], sdi}.
  - After div cycles, enter LOW.
- LOW (div cycles, sck=0):
  - On the entry edge (sck 1->0), if bit<size-1: tx shifts left, sdo=next bit, bit increments.
  - After div cycles: enter HIGH if bit<size-1; else _scs<=1, sdo<=0, enter GAP.
  - The last LOW phase is the _scs hold time.
- GAP (div cycles, _scs=1, sck=0, busy=1):
  - On GAP entry, pdo <= rx and done=1 for exactly that one cycle.
  - After div cycles, busy=0 and return to IDLE.
  - GAP is the minimum deselect time between frames.
- Timing per frame:
  - exactly size rising sck edges
  - busy high for div*(2*size+2) cycles
  - _scs low for div*(2*size+1) cycles
  - next start accepted at the earliest on the cycle busy=0 (back-to-back allowed)
- start while busy=1 is ignored and not queued.
- Signal rules:
  - sdo is stable for the whole HIGH phase.
  - sck and _scs never change in the same cycle.
  - sck is low whenever _scs=1.
- Bit order:
  - TX: pdi[size-1] is sent first.
  - RX: the first sampled bit lands in pdo[size-1].
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset: hold _rst=0 for 3 cycles with start=1 -> _scs=1, sck=0, sdo=0, busy=0, done=0, pdo=0 throughout.
2. Loopback (sdi tied to sdo), size=66, div=4, pdi=66'h2_DEAD_BEEF_0123_4567 -> done after exactly 536 busy cycles, pdo=pdi, 66 sck rising edges counted, _scs low for 532 cycles.
3. Bit order: size=8, div=2, pdi=8'hA5, behavioural slave returning 8'h3C -> slave captures 0xA5 MSB-first on sck rising edges; pdo=8'h3C; done pulses once.
4. Start while busy: second start with pdi=66'h0 mid-frame -> ignored, first frame completes unchanged; a new start the cycle busy falls is accepted and _scs falls at the next cycle.
5. Reset mid-frame: _rst=0 during bit 20 -> next edge _scs=1, sck=0, busy=0; no done; pdo keeps its previous value of 0.
6. Minimum divider: div=1, size=4, sdi=1 constant -> pdo=4'hF, busy high 10 cycles, sck toggles every cycle during the frame.

Source files
------------

// File: rtl/spm.sv
// SPI initiator (mode 0) for the frequency meter's slave port: one
// full-duplex frame of `size` bits per accepted start, MSB first.
module spm #(
    parameter int unsigned size = 66,
    parameter int unsigned div  = 4
) (
    input  logic            clk,
    input  logic            _rst,
    input  logic            start,
    input  logic [size-1:0] pdi,
    output logic [size-1:0] pdo,
    output logic            busy,
    output logic            done,
    output logic            sck,
    output logic            sdo,
    input  logic            sdi,
    output logic            _scs
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] PH_LAST  = CW'(div - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(size - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   phase;
    logic [CW-1:0]   bit_cnt;
    logic [size-1:0] tx;
    logic [size-1:0] rx;
    logic            last;
    logic            phase_end;
    logic [size-1:0] tx_shift;

    assign phase_end = (phase == PH_LAST);
    assign tx_shift  = tx << 1;

    // last marks that the current LOW phase follows the final bit, so it ends the frame
    always_ff @(posedge clk) begin
        if (!_rst) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            last    <= 1'b0;
            pdo     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            sdo     <= 1'b0;
            _scs    <= 1'b1;
        end else begin
            done  <= 1'b0;
            phase <= phase + CW'(1);
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (start) begin
                        tx      <= pdi;
                        sdo     <= pdi[size-1];
                        _scs    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        last    <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        phase <= '0;
                        sck   <= 1'b1;
                        rx    <= {rx[size-2:0], sdi};
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase <= '0;
                        sck   <= 1'b0;
                        state <= LOW;
                        if (bit_cnt < BIT_LAST) begin
                            tx      <= tx_shift;
                            sdo     <= tx_shift[size-1];
                            bit_cnt <= bit_cnt + CW'(1);
                            last    <= 1'b0;
                        end else begin
                            last <= 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        phase <= '0;
                        if (last) begin
                            _scs  <= 1'b1;
                            sdo   <= 1'b0;
                            pdo   <= rx;
                            done  <= 1'b1;
                            state <= GAP;
                        end else begin
                            sck   <= 1'b1;
                            rx    <= {rx[size-2:0], sdi};
                            state <= HIGH;
                        end
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        phase <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    phase <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm.sv
// Self-checking bench for spm: three instances cover the default frame,
// a short frame against a behavioural slave, and the minimum divider.
module tb_spm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [65:0] exp_q[$];

    // instance A: size=66, div=4
    logic        a_rst, a_start, a_loop;
    logic [65:0] a_pdi, a_pdo;
    logic        a_busy, a_done, a_sck, a_sdo, a_sdi, a_scs;
    assign a_sdi = a_loop ? a_sdo : 1'b0;

    // instance B: size=8, div=2 ; instance C: size=4, div=1
    logic        bc_rst;
    logic        b_start, b_busy, b_done, b_sck, b_sdo, b_sdi, b_scs;
    logic [7:0]  b_pdi, b_pdo;
    logic        c_start, c_busy, c_done, c_sck, c_sdo, c_sdi, c_scs;
    logic [3:0]  c_pdi, c_pdo;

    spm #(.size(66), .div(4)) u_a (
        .clk(clk), ._rst(a_rst), .start(a_start), .pdi(a_pdi), .pdo(a_pdo),
        .busy(a_busy), .done(a_done), .sck(a_sck), .sdo(a_sdo), .sdi(a_sdi), ._scs(a_scs)
    );
    spm #(.size(8), .div(2)) u_b (
        .clk(clk), ._rst(bc_rst), .start(b_start), .pdi(b_pdi), .pdo(b_pdo),
        .busy(b_busy), .done(b_done), .sck(b_sck), .sdo(b_sdo), .sdi(b_sdi), ._scs(b_scs)
    );
    spm #(.size(4), .div(1)) u_c (
        .clk(clk), ._rst(bc_rst), .start(c_start), .pdi(c_pdi), .pdo(c_pdo),
        .busy(c_busy), .done(c_done), .sck(c_sck), .sdo(c_sdo), .sdi(c_sdi), ._scs(c_scs)
    );

    // Runs one frame on A from an idle negedge; returns at the first negedge with busy=0.
    task automatic run_a(input logic [65:0] data, input int inj,
                         output int nbusy, output int nscs, output int nrise,
                         output int ndone, output int nbad, output logic scs_first,
                         output logic [65:0] got, output logic timeout);
        logic prev_sck, prev_scs;
        nbusy = 0; nscs = 0; nrise = 0; ndone = 0; nbad = 0; got = '0; timeout = 1'b1;
        prev_sck = a_sck;
        prev_scs = a_scs;
        a_pdi   = data;
        a_start = 1'b1;
        exp_q.push_back(data);
        @(negedge clk);
        a_start   = 1'b0;
        a_pdi     = ~data;
        scs_first = a_scs;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) @(negedge clk);
            if (i == inj) begin
                a_start = 1'b1;
                a_pdi   = '0;
            end else if (i == inj + 1) begin
                a_start = 1'b0;
            end
            if (!a_busy) begin
                timeout = 1'b0;
                break;
            end
            nbusy++;
            if (!a_scs) nscs++;
            if (a_sck && !prev_sck) nrise++;
            if (a_scs && a_sck) nbad++;
            if ((a_scs !== prev_scs) && (a_sck !== prev_sck)) nbad++;
            if (a_done) begin
                ndone++;
                got = a_pdo;
            end
            prev_sck = a_sck;
            prev_scs = a_scs;
        end
    endtask

    task automatic test_reset;
        a_rst = 1'b0; bc_rst = 1'b0;
        a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (a_scs !== 1'b1) begin errors++; $display("FAIL reset_scs: got %b expected 1", a_scs); end
            checks++; if (a_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", a_sck); end
            checks++; if (a_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", a_sdo); end
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
            checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
            checks++; if (a_pdo !== 66'h0) begin errors++; $display("FAIL reset_pdo: got %h expected 0", a_pdo); end
            checks++; if ({b_scs, b_busy, c_scs, c_busy} !== 4'b1010) begin
                errors++; $display("FAIL reset_bc: got %b expected 1010", {b_scs, b_busy, c_scs, c_busy});
            end
        end
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_rst = 1'b1; bc_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback;
        int nbusy, nscs, nrise, ndone, nbad;
        logic sf, to;
        logic [65:0] got, exp;
        a_loop = 1'b1;
        run_a(66'h2_DEAD_BEEF_0123_4567, -1, nbusy, nscs, nrise, ndone, nbad, sf, got, to);
        exp = exp_q.pop_front();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL loop_timeout: busy never fell"); end
        checks++; if (nbusy != 536) begin errors++; $display("FAIL loop_busy: got %0d expected 536", nbusy); end
        checks++; if (nscs != 532) begin errors++; $display("FAIL loop_scs_low: got %0d expected 532", nscs); end
        checks++; if (nrise != 66) begin errors++; $display("FAIL loop_sck_rises: got %0d expected 66", nrise); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL loop_done_count: got %0d expected 1", ndone); end
        checks++; if (nbad != 0) begin errors++; $display("FAIL loop_sck_scs_rules: got %0d violations expected 0", nbad); end
        checks++; if (sf !== 1'b0) begin errors++; $display("FAIL loop_scs_fall: got %b expected 0", sf); end
        checks++; if (got !== exp) begin errors++; $display("FAIL loop_pdo: got %h expected %h", got, exp); end
    endtask

    task automatic test_start_while_busy;
        int nbusy, nscs, nrise, ndone, nbad;
        logic sf, to;
        logic [65:0] got, exp;
        a_loop = 1'b1;
        run_a(66'h1_3579_BDF0_2468_ACE1, 100, nbusy, nscs, nrise, ndone, nbad, sf, got, to);
        exp = exp_q.pop_front();
        checks++; if (to !== 1'b0 || nbusy != 536) begin errors++; $display("FAIL busy_ignore_len: got %0d expected 536", nbusy); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_ignore_done: got %0d expected 1", ndone); end
        checks++; if (got !== exp) begin errors++; $display("FAIL busy_ignore_pdo: got %h expected %h", got, exp); end
        run_a(66'h3_0F0F_1234_8765_FFFF, -1, nbusy, nscs, nrise, ndone, nbad, sf, got, to);
        exp = exp_q.pop_front();
        checks++; if (sf !== 1'b0) begin errors++; $display("FAIL b2b_scs_fall: got %b expected 0", sf); end
        checks++; if (to !== 1'b0 || nbusy != 536) begin errors++; $display("FAIL b2b_len: got %0d expected 536", nbusy); end
        checks++; if (got !== exp) begin errors++; $display("FAIL b2b_pdo: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_midframe;
        int ndone;
        ndone = 0;
        a_rst = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        checks++; if (a_pdo !== 66'h0) begin errors++; $display("FAIL mid_pre_pdo: got %h expected 0", a_pdo); end
        a_pdi = 66'h2_AAAA_5555_AAAA_5555;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        // bit 20 HIGH phase spans cycles 164..167 after _scs falls
        for (int i = 0; i < 166; i++) begin
            if (a_done) ndone++;
            @(negedge clk);
        end
        checks++; if (a_scs !== 1'b0 || a_sck !== 1'b1) begin
            errors++; $display("FAIL mid_in_frame: got scs=%b sck=%b expected scs=0 sck=1", a_scs, a_sck);
        end
        a_rst = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        checks++; if (a_scs !== 1'b1) begin errors++; $display("FAIL mid_scs: got %b expected 1", a_scs); end
        checks++; if (a_sck !== 1'b0) begin errors++; $display("FAIL mid_sck: got %b expected 0", a_sck); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", a_busy); end
        checks++; if (a_pdo !== 66'h0) begin errors++; $display("FAIL mid_pdo: got %h expected 0", a_pdo); end
        for (int i = 0; i < 20; i++) begin
            if (a_done || a_busy) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL mid_no_done: got %0d done/busy cycles expected 0", ndone); end
    endtask

    task automatic test_bit_order;
        logic prev_sck, prev_scs, to;
        logic [7:0] s_tx, s_rx;
        logic [65:0] got, exp;
        int nbusy, nrise, ndone;
        nbusy = 0; nrise = 0; ndone = 0; got = '0; to = 1'b1;
        s_tx = 8'h3C; s_rx = 8'h00; b_sdi = 1'b0;
        prev_sck = b_sck;
        prev_scs = b_scs;
        b_pdi = 8'hA5;
        b_start = 1'b1;
        exp_q.push_back(66'(8'h3C));
        @(negedge clk);
        b_start = 1'b0;
        b_pdi = 8'h00;
        for (int i = 0; i < 500; i++) begin
            if (!b_busy) begin
                to = 1'b0;
                break;
            end
            if (prev_scs && !b_scs) b_sdi = s_tx[7];
            if (!prev_sck && b_sck) begin
                s_rx = {s_rx[6:0], b_sdo};
                nrise++;
            end
            if (prev_sck && !b_sck && !b_scs) begin
                s_tx = {s_tx[6:0], 1'b0};
                b_sdi = s_tx[7];
            end
            nbusy++;
            if (b_done) begin
                ndone++;
                got = 66'(b_pdo);
            end
            prev_sck = b_sck;
            prev_scs = b_scs;
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++; if (to !== 1'b0 || nbusy != 36) begin errors++; $display("FAIL order_busy: got %0d expected 36", nbusy); end
        checks++; if (s_rx !== 8'hA5) begin errors++; $display("FAIL order_slave_rx: got %h expected a5", s_rx); end
        checks++; if (nrise != 8) begin errors++; $display("FAIL order_sck_rises: got %0d expected 8", nrise); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL order_done: got %0d expected 1", ndone); end
        checks++; if (got !== exp) begin errors++; $display("FAIL order_pdo: got %h expected %h", got, exp); end
    endtask

    task automatic test_min_div;
        logic [9:0] pat;
        logic [65:0] got, exp;
        int nbusy, ndone;
        logic to;
        pat = '0; nbusy = 0; ndone = 0; got = '0; to = 1'b1;
        c_sdi = 1'b1;
        c_pdi = 4'h6;
        c_start = 1'b1;
        exp_q.push_back(66'(4'hF));
        @(negedge clk);
        c_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!c_busy) begin
                to = 1'b0;
                break;
            end
            pat = {pat[8:0], c_sck};
            nbusy++;
            if (c_done) begin
                ndone++;
                got = 66'(c_pdo);
            end
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++; if (to !== 1'b0 || nbusy != 10) begin errors++; $display("FAIL mindiv_busy: got %0d expected 10", nbusy); end
        checks++; if (pat !== 10'b0101010100) begin errors++; $display("FAIL mindiv_sck_pattern: got %b expected 0101010100", pat); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL mindiv_done: got %0d expected 1", ndone); end
        checks++; if (got !== exp) begin errors++; $display("FAIL mindiv_pdo: got %h expected %h", got, exp); end
        checks++; if (c_scs !== 1'b1 || c_sdo !== 1'b0) begin
            errors++; $display("FAIL mindiv_idle: got scs=%b sdo=%b expected scs=1 sdo=0", c_scs, c_sdo);
        end
    endtask

    initial begin
        a_loop = 1'b0; a_pdi = '0; b_pdi = '0; c_pdi = '0;
        b_sdi = 1'b0; c_sdi = 1'b0;
        test_reset();
        test_loopback();
        test_start_while_busy();
        test_reset_midframe();
        test_bit_order();
        test_min_div();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
